// File: rtl/mext_pkg.sv
// mext_pkg: shared types for the RV32M multiply issue controller.
//   mul_op_t       2-bit multiplier opcode (MUL, MULH, MULHSU, MULHU)
//   issue_state_t  issue FSM states
//   F3_*           funct3 encodings of the supported multiply ops
//   cache_entry_t  last-result cache entry {valid, op, a, b, data}
//   decode_op      funct3 -> multiplier opcode
package mext_pkg;

    localparam int unsigned MEXT_XLEN = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        DRAIN,
        RESP
    } issue_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    // funct3[2] set selects the divide group, which this block does not handle.
    localparam int unsigned F3_DIV_BIT = 2;

    typedef struct packed {
        logic                 valid;
        mul_op_t              op;
        logic [MEXT_XLEN-1:0] a;
        logic [MEXT_XLEN-1:0] b;
        logic [MEXT_XLEN-1:0] data;
    } cache_entry_t;

    function automatic mul_op_t decode_op(input logic [2:0] f3);
        case (f3)
            F3_MUL:    return MUL;
            F3_MULH:   return MULH;
            F3_MULHSU: return MULHSU;
            F3_MULHU:  return MULHU;
            default:   return MUL;
        endcase
    endfunction

endpackage

// File: rtl/mext_result_cache.sv
// mext_result_cache: single-entry {op, a, b} -> result cache.
//   clk, rst          clock, synchronous active-high reset (invalidates the entry)
//   we, wr_entry      write the whole entry
//   lk_op, lk_a, lk_b lookup key for the incoming request
//   hit, hit_data     key matches a valid entry; stored result
module mext_result_cache
    import mext_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  cache_entry_t         wr_entry,
    input  mul_op_t              lk_op,
    input  logic [MEXT_XLEN-1:0] lk_a,
    input  logic [MEXT_XLEN-1:0] lk_b,
    output logic                 hit,
    output logic [MEXT_XLEN-1:0] hit_data
);

    cache_entry_t entry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else if (we) begin
            entry_q <= wr_entry;
        end
    end

    // Opcode is part of the key: same operands under another opcode must miss.
    assign hit = entry_q.valid & (entry_q.op == lk_op) & (entry_q.a == lk_a) &
                 (entry_q.b == lk_b);
    assign hit_data = entry_q.data;

endmodule

// File: rtl/mext_issue_ctrl.sv
// mext_issue_ctrl: issue/writeback control in front of the iterative multiplier.
//   clk, rst                         clock, synchronous active-high reset
//   req_valid, funct3, rs1_data,
//   rs2_data, rd_addr                M-extension request from execute
//   flush                            kill the in-flight request
//   mul_done, mul_result             multiplier completion pulse and result
//   mul_start, mul_opcode,
//   mul_op_a, mul_op_b               registered multiplier command
//   stall                            hold the upstream pipeline
//   wb_valid, wb_rd, wb_data         writeback strobe, destination, result
//   illegal_op                       divide-group funct3 seen in IDLE
//   timeout_err                      watchdog abort pulse
module mext_issue_ctrl
    import mext_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TIMEOUT  = 63,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    input  logic            mul_done,
    input  logic [XLEN-1:0] mul_result,
    output logic            mul_start,
    output logic [1:0]      mul_opcode,
    output logic [XLEN-1:0] mul_op_a,
    output logic [XLEN-1:0] mul_op_b,
    output logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal_op,
    output logic            timeout_err
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    issue_state_t    state_q;
    mul_op_t         op_q;
    logic [WdW-1:0]  wd_q;
    mul_op_t         req_op;
    logic            accept;
    logic            wd_expired;
    logic            waiting;
    logic            cache_hit;
    logic [XLEN-1:0] cache_data;
    logic            cache_we;
    cache_entry_t    cache_wr;

    assign req_op     = decode_op(funct3);
    assign accept     = (state_q == IDLE) & req_valid & ~flush & ~funct3[F3_DIV_BIT];
    assign waiting    = (state_q == WAIT) | (state_q == DRAIN);
    // A done arriving in the expiry cycle wins: the result is still good.
    assign wd_expired = waiting & ~mul_done & (wd_q == WdW'(TIMEOUT));

    assign mul_opcode  = op_q;
    assign stall       = accept | (state_q == START) | waiting;
    assign wb_valid    = (state_q == RESP) & ~flush;
    assign illegal_op  = (state_q == IDLE) & req_valid & ~flush & funct3[F3_DIV_BIT];
    assign timeout_err = wd_expired;

    // A result finishing in WAIT is correct even if flushed, so it is cached;
    // results drained after a flush in START/WAIT are not.
    assign cache_we = (state_q == WAIT) & mul_done;

    always_comb begin
        cache_wr       = '0;
        cache_wr.valid = 1'b1;
        cache_wr.op    = op_q;
        cache_wr.a     = mul_op_a;
        cache_wr.b     = mul_op_b;
        cache_wr.data  = mul_result;
    end

    if (CACHE_EN) begin : g_cache
        mext_result_cache u_cache (
            .clk      (clk),
            .rst      (rst),
            .we       (cache_we),
            .wr_entry (cache_wr),
            .lk_op    (req_op),
            .lk_a     (rs1_data),
            .lk_b     (rs2_data),
            .hit      (cache_hit),
            .hit_data (cache_data)
        );
    end else begin : g_no_cache
        assign cache_hit  = 1'b0;
        assign cache_data = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= MUL;
            wd_q      <= '0;
            mul_start <= 1'b0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            mul_start <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        wb_rd <= rd_addr;
                        if (cache_hit) begin
                            wb_data <= cache_data;
                            state_q <= RESP;
                        end else begin
                            op_q      <= req_op;
                            mul_op_a  <= rs1_data;
                            mul_op_b  <= rs2_data;
                            mul_start <= 1'b1;
                            state_q   <= START;
                        end
                    end
                end
                START: begin
                    wd_q    <= '0;
                    state_q <= flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        if (!flush) begin
                            wb_data <= mul_result;
                        end
                        state_q <= flush ? IDLE : RESP;
                    end else if (wd_expired) begin
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                        if (flush) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The multiplier cannot be aborted; wait it out and drop the result.
                    if (mul_done || wd_expired) begin
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mext_issue_ctrl.sv
module tb_mext_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        mul_start;
    logic [1:0]  mul_opcode;
    logic [31:0] mul_op_a;
    logic [31:0] mul_op_b;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_op;
    logic        timeout_err;

    always #5 clk = ~clk;

    mext_issue_ctrl #(
        .XLEN     (32),
        .TIMEOUT  (63),
        .CACHE_EN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .funct3      (funct3),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_addr     (rd_addr),
        .flush       (flush),
        .mul_done    (mul_done),
        .mul_result  (mul_result),
        .mul_start   (mul_start),
        .mul_opcode  (mul_opcode),
        .mul_op_a    (mul_op_a),
        .mul_op_b    (mul_op_b),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal_op  (illegal_op),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference multiplier: D cycles from mul_start to a one-cycle mul_done.
    int unsigned mdl_d    = 5;
    bit          mdl_hang = 1'b0;
    bit          mdl_busy = 1'b0;
    int unsigned mdl_rem  = 0;
    logic [31:0] mdl_res  = '0;

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00:   p = ua * ub;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    assign mul_done   = mdl_busy && (mdl_rem == 0);
    assign mul_result = mdl_res;

    always @(posedge clk) begin
        if (rst) begin
            mdl_busy <= 1'b0;
        end else if (mul_start) begin
            mdl_busy <= !mdl_hang;
            mdl_rem  <= mdl_d - 1;
            mdl_res  <= ref_mul(mul_opcode, mul_op_a, mul_op_b);
        end else if (mdl_busy) begin
            if (mdl_rem == 0) mdl_busy <= 1'b0;
            else              mdl_rem  <= mdl_rem - 1;
        end
    end

    // Scoreboard: expectations pushed at issue, popped on each wb_valid.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;

    always @(negedge clk) begin
        #2;
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual rd=%0d data=%0h expected=no writeback",
                         wb_rd, wb_data);
            end else begin
                sb_e = sb_q.pop_front();
                chk("wb_rd", 64'(wb_rd), 64'(sb_e.rd));
                chk("wb_data", 64'(wb_data), 64'(sb_e.data));
            end
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          d;
        logic [31:0] exp;
        bit          hit;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic idle_inputs();
        req_valid = 1'b0;
        funct3    = 3'b000;
        rs1_data  = '0;
        rs2_data  = '0;
        rd_addr   = '0;
        flush     = 1'b0;
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        @(negedge clk);
        req_valid = 1'b1;
        funct3    = f3;
        rs1_data  = a;
        rs2_data  = b;
        rd_addr   = rd;
    endtask

    task automatic run_req(input vec_t v, input string tag);
        int          lat;
        int          starts;
        int          start_cyc;
        bit          stall_ok;
        logic [1:0]  op_seen;
        logic [31:0] a_seen;
        logic [31:0] b_seen;
        lat = -1; starts = 0; start_cyc = -1; stall_ok = 1'b1;
        op_seen = '0; a_seen = '0; b_seen = '0;
        mdl_d = v.d;
        drive_req(v.f3, v.a, v.b, v.rd);
        sb_q.push_back('{rd: v.rd, data: v.exp});
        #1;
        chk({tag, "_stall_c0"}, 64'(stall), 64'(1));
        for (int c = 1; c <= 200 && lat < 0; c++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (mul_start === 1'b1) begin
                starts++;
                start_cyc = c;
                op_seen = mul_opcode;
                a_seen  = mul_op_a;
                b_seen  = mul_op_b;
            end
            if (wb_valid === 1'b1) begin
                lat = c;
                if (stall !== 1'b0) stall_ok = 1'b0;
            end else if (stall !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
        chk({tag, "_starts"}, 64'(starts), v.hit ? 64'(0) : 64'(1));
        chk({tag, "_stall"}, 64'(stall_ok), 64'(1));
        if (!v.hit) begin
            chk({tag, "_start_cyc"}, 64'(start_cyc), 64'(1));
            chk({tag, "_opcode"}, 64'(op_seen), 64'(v.f3[1:0]));
            chk({tag, "_op_a"}, 64'(a_seen), 64'(v.a));
            chk({tag, "_op_b"}, 64'(b_seen), 64'(v.b));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=still running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int   drop;
        int   to_cyc;
        int   to_cnt;
        bit   wb_seen;
        vec_t v;

        vecs[0] = '{3'b000, 32'd7,         32'd6,         5'd5,  34, 32'd42,        1'b0, 36};
        vecs[1] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  5,  32'hFFFF_FFFE, 1'b0, 7};
        vecs[2] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  5,  32'h0000_0000, 1'b0, 7};
        vecs[3] = '{3'b010, 32'hFFFF_FFFE, 32'd3,         5'd8,  5,  32'hFFFF_FFFF, 1'b0, 7};
        vecs[4] = '{3'b010, 32'hFFFF_FFFE, 32'd3,         5'd9,  5,  32'hFFFF_FFFF, 1'b1, 1};
        vecs[5] = '{3'b011, 32'hFFFF_FFFE, 32'd3,         5'd10, 3,  32'h0000_0002, 1'b0, 5};
        vecs[6] = '{3'b000, 32'hFFFF_FFFF, 32'd2,         5'd11, 1,  32'hFFFF_FFFE, 1'b0, 3};
        vecs[7] = '{3'b000, 32'hFFFF_FFFF, 32'd2,         5'd12, 1,  32'hFFFF_FFFE, 1'b1, 1};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outputs",
            {mul_start, mul_opcode, mul_op_a, stall, wb_valid, wb_rd, illegal_op, timeout_err},
            '0);
        chk("reset_op_b_data", {mul_op_b, wb_data}, '0);

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush in WAIT: stall holds until the drained done, no writeback, no cache write.
        mdl_d = 20;
        drive_req(3'b000, 32'd9, 32'd9, 5'd3);
        drop = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 10) flush = 1'b1;
            #1;
            if (drop < 0 && stall === 1'b0) drop = c;
        end
        chk("flush_wait_stall_drop", 64'(drop), 64'(22));
        v = '{3'b000, 32'd9, 32'd9, 5'd3, 4, 32'd81, 1'b0, 6};
        run_req(v, "flush_repeat_miss");

        // Flush together with done in WAIT: dropped, but the cache is still written.
        mdl_d = 6;
        drive_req(3'b000, 32'd11, 32'd11, 5'd13);
        drop = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 7) flush = 1'b1;
            #1;
            if (drop < 0 && stall === 1'b0) drop = c;
        end
        chk("flush_done_stall_drop", 64'(drop), 64'(8));
        v = '{3'b000, 32'd11, 32'd11, 5'd14, 6, 32'd121, 1'b1, 1};
        run_req(v, "flush_done_repeat_hit");

        // Watchdog: the multiplier never answers.
        mdl_hang = 1'b1;
        drive_req(3'b000, 32'd3, 32'd3, 5'd4);
        to_cyc = -1; to_cnt = 0; drop = -1; wb_seen = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (timeout_err === 1'b1) begin
                to_cnt++;
                to_cyc = c;
            end
            if (wb_valid === 1'b1) wb_seen = 1'b1;
            if (drop < 0 && stall === 1'b0) drop = c;
        end
        mdl_hang = 1'b0;
        chk("timeout_cycle", 64'(to_cyc), 64'(65));
        chk("timeout_count", 64'(to_cnt), 64'(1));
        chk("timeout_stall_drop", 64'(drop), 64'(66));
        chk("timeout_no_wb", 64'(wb_seen), 64'(0));

        // Divide-group funct3.
        drive_req(3'b100, 32'd5, 32'd6, 5'd1);
        #1;
        chk("illegal_pulse", {illegal_op, stall, mul_start}, 64'b100);
        @(negedge clk);
        funct3 = 3'b101;
        flush  = 1'b1;
        #1;
        chk("illegal_flushed", {illegal_op, stall, mul_start}, 64'b000);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("illegal_after", {illegal_op, stall, mul_start}, 64'b000);

        // Reset during WAIT clears everything, including the cache.
        v = '{3'b000, 32'd5, 32'd5, 5'd2, 4, 32'd25, 1'b0, 6};
        run_req(v, "pre_reset");
        mdl_d = 10;
        drive_req(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd15);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            idle_inputs();
            rst = (c == 4);
            #1;
        end
        chk("midrst_outputs",
            {mul_start, mul_opcode, mul_op_a, stall, wb_valid, wb_rd, illegal_op, timeout_err},
            '0);
        chk("midrst_op_b_data", {mul_op_b, wb_data}, '0);
        v = '{3'b000, 32'd5, 32'd5, 5'd2, 4, 32'd25, 1'b0, 6};
        run_req(v, "post_reset_miss");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
